vec_mem_sequencer: RTL and testbench
====================================

// Module: vec_mem_sequencer
// PURPOSE
//   Memory-stage controller for the vector pipeline. When the EX/MEM register holds a vector
//   load or store, it serialises the LANES per-lane accesses onto one single-word memory port.
//   It stalls the whole pipeline until every lane is done. Load results return as a full vector
//   for the MEM/WB stage.
// PARAMETERS
//   LANES  16  vector lanes per instruction (power of 2, >=2)
//   DW     32  data width per lane
//   AW     32  memory word-address width (lane address = low AW bits of ALUResultM[i])
// PORTS
//   CLK         in   1          clock, rising edge
//   RST         in   1          reset, asynchronous, active-high
//   MemWriteM   in   1          M-stage instruction is a vector store
//   MemtoRegM   in   1          M-stage instruction is a vector load
//   ALUResultM  in   LANES*DW   per-lane word addresses (lane i = [i])
//   WriteDataM  in   LANES*DW   per-lane store data
//   StallM      out  1          freeze PC and the F/D, D/E, E/M pipeline registers while high
//   ReadDataM   out  LANES*DW   gathered load data (buffer)
//   ReadValidM  out  1          1-cycle pulse: ReadDataM complete for current load
//   mem_req     out  1          memory request
//   mem_we      out  1          1 = write, 0 = read
//   mem_addr    out  AW         word address
//   mem_wdata   out  DW         write data
//   mem_ack     in   1          access complete this cycle (rdata valid for reads)
//   mem_rdata   in   DW         read data
// BEHAVIOUR
//   - Reset values: FSM=IDLE, lane=0, StallM=0, ReadValidM=0, mem_req=0, mem_we=0,
//     mem_addr=0, mem_wdata=0, ReadDataM=0, latched addr/data buffers=0.
//   - FSM states: IDLE -> ACCESS -> DONE -> IDLE.
//   - IDLE:
//     - Trigger is MemWriteM|MemtoRegM.
//     - On trigger: StallM=1 combinationally in the same cycle.
//     - On trigger, latch ALUResultM and WriteDataM. Latch op as write if MemWriteM=1, else read.
//     - Both MemWriteM and MemtoRegM high is treated as a store.
//     - On trigger, set lane=0 and go to ACCESS.
//   - ACCESS:
//     - Outputs: StallM=1, mem_req=1, mem_we=latched op, mem_addr=addr_buf[lane], mem_wdata=wdata_buf[lane].
//     - Outputs are held stable until mem_ack.
//     - On mem_ack for a read: ReadDataM[lane] <= mem_rdata.
//     - On mem_ack with lane==LANES-1: go to DONE, mem_req drops next cycle. Otherwise lane <= lane+1.
//     - Back-to-back requests: the next lane's request is presented the cycle after the ack.
//   - DONE:
//     - StallM=0 and mem_req=0.
//     - ReadValidM=1 for this cycle only, for loads only.
//     - The pipeline advances at the end of DONE. Next state is unconditionally IDLE.
//     - The M-stage request still visible in DONE is not re-accepted.
//   - Latency: with zero-wait ack, StallM is high for LANES+1 cycles (trigger + LANES accesses).
//     ReadValidM follows on the next cycle. Each wait-state cycle adds one stall cycle.
//   - Inputs ALUResultM/WriteDataM/MemWriteM/MemtoRegM are ignored outside IDLE; latched copies are used.
//   - mem_ack while mem_req=0 is ignored.
//   - lane counter is $clog2(LANES) bits; it never wraps past LANES-1 within one instruction.
//   - ReadDataM holds its last load result until the next load overwrites it lane by lane.
//   - Stores do not modify ReadDataM.
//   - RST mid-operation: immediate return to reset values. The partial vector is discarded
//     and no ReadValidM pulse is produced.
// TESTING
//   1. Load, addr[i]=0x100+i, memory returns 0xA000+i, zero-wait -> StallM high 17 cycles,
//      then ReadValidM 1 cycle, ReadDataM[i]=0xA000+i.
//   2. Store, addr[i]=0x200+4*i, data[i]=i*3 -> 16 writes in lane order 0..15 with matching
//      addr/data, mem_we=1, ReadValidM never pulses.
//   3. Load with mem_ack delayed 2 cycles on lane 5 only -> mem_addr/mem_we held; StallM
//      high 19 cycles; ReadDataM[5] correct.
//   4. MemWriteM=MemtoRegM=1 -> treated as store; spurious mem_ack in IDLE -> no state change.
//   5. RST asserted while lane=7 of a load -> next edge: mem_req=0, StallM=0, FSM IDLE,
//      ReadDataM=0. A new load afterwards completes normally.
//   6. Two back-to-back loads (different addresses) -> exactly one ReadValidM per load;
//      the second load's data replaces the first.

Source files
------------

// File: rtl/vec_mem_sequencer_if.sv
// rtl/vec_mem_sequencer_if.sv - single-word memory port between the vector sequencer and memory
interface vec_mem_sequencer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/vec_mem_sequencer.sv
// rtl/vec_mem_sequencer.sv - serialises vector load/store lanes onto one memory port
module vec_mem_sequencer #(
  parameter int LANES = 16,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                MemWriteM,
  input  logic                MemtoRegM,
  input  logic [LANES*DW-1:0] ALUResultM,
  input  logic [LANES*DW-1:0] WriteDataM,
  output logic                StallM,
  output logic [LANES*DW-1:0] ReadDataM,
  output logic                ReadValidM,
  vec_mem_sequencer_if.master mem
);
  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  state_t        nextState;
  logic [LW-1:0] lane;
  logic          opWrite;
  logic [AW-1:0] addrBuf  [LANES];
  logic [DW-1:0] wdataBuf [LANES];

  logic trigger;
  logic lastLane;
  logic laneDone;

  // Store wins when both op flags are set, so only MemWriteM decides the latched op.
  assign trigger  = MemWriteM | MemtoRegM;
  assign lastLane = (lane == LAST_LANE);
  assign laneDone = (state == ACCESS) && mem.mem_ack;

  // State register; reset abandons any partial vector immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  // Next state: DONE always returns to IDLE so the held M-stage op is not re-accepted.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (trigger) nextState = ACCESS;
      ACCESS:  if (mem.mem_ack && lastLane) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand latching, lane stepping and load-data gathering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lane      <= '0;
      opWrite   <= 1'b0;
      ReadDataM <= '0;
      for (int i = 0; i < LANES; i++) begin
        addrBuf[i]  <= '0;
        wdataBuf[i] <= '0;
      end
    end else begin
      if (state == IDLE && trigger) begin
        lane    <= '0;
        opWrite <= MemWriteM;
        for (int i = 0; i < LANES; i++) begin
          addrBuf[i]  <= ALUResultM[i*DW +: AW];
          wdataBuf[i] <= WriteDataM[i*DW +: DW];
        end
      end
      if (laneDone) begin
        if (!opWrite) ReadDataM[int'(lane)*DW +: DW] <= mem.mem_rdata;
        if (!lastLane) lane <= lane + LW'(1);
      end
    end
  end

  // Outputs: stall starts combinationally on trigger and ends when DONE is reached.
  always_comb begin
    StallM        = 1'b0;
    ReadValidM    = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      IDLE: StallM = trigger & ~RST;
      ACCESS: begin
        StallM        = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_we    = opWrite;
        mem.mem_addr  = addrBuf[lane];
        mem.mem_wdata = wdataBuf[lane];
      end
      DONE:    ReadValidM = ~opWrite;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb/tb_vec_mem_sequencer.sv - scoreboard bench for the vector memory sequencer
`timescale 1ns/1ps
module tb_vec_mem_sequencer;
  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int VW    = LANES * DW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          MemWriteM;
  logic          MemtoRegM;
  logic [VW-1:0] ALUResultM;
  logic [VW-1:0] WriteDataM;
  logic          StallM;
  logic [VW-1:0] ReadDataM;
  logic          ReadValidM;

  vec_mem_sequencer_if #(.AW(AW), .DW(DW)) memIf ();

  vec_mem_sequencer #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .MemWriteM  (MemWriteM),
    .MemtoRegM  (MemtoRegM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .ReadValidM (ReadValidM),
    .mem        (memIf.master)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          expTxn[$];
  logic [VW-1:0] expRead[$];
  txn_t          monTxn;
  logic [VW-1:0] monRead;
  int            rvCount = 0;

  logic [AW-1:0] waitAddr = '1;
  int            waitNeed = 0;
  int            waitCnt  = 0;
  logic          spurAck  = 1'b0;

  // Memory model: read data is address + 0x9F00; one chosen address gets wait states.
  assign memIf.mem_ack   = spurAck || (memIf.mem_req &&
                           (waitCnt >= ((memIf.mem_addr == waitAddr) ? waitNeed : 0)));
  assign memIf.mem_rdata = memIf.mem_addr + 32'h9F00;

  // Counts cycles the current request has been waiting.
  always @(posedge CLK) waitCnt <= (memIf.mem_req && !memIf.mem_ack) ? waitCnt + 1 : 0;

  logic          holdPend = 1'b0;
  logic [AW-1:0] holdAddr;
  logic          holdWe;
  logic [DW-1:0] holdWd;

  // Monitor: request hold stability, memory transaction and load-result scoreboards.
  always @(negedge CLK) begin
    #2;
    if (holdPend && memIf.mem_req) begin
      total++;
      if (memIf.mem_addr !== holdAddr || memIf.mem_we !== holdWe || memIf.mem_wdata !== holdWd) begin
        bad++;
        $display("FAIL req_hold addr=%h/%h we=%b/%b wdata=%h/%h (got/want)",
                 memIf.mem_addr, holdAddr, memIf.mem_we, holdWe, memIf.mem_wdata, holdWd);
      end
    end
    holdPend = memIf.mem_req && !memIf.mem_ack;
    holdAddr = memIf.mem_addr;
    holdWe   = memIf.mem_we;
    holdWd   = memIf.mem_wdata;
    if (memIf.mem_req && memIf.mem_ack) begin
      total++;
      if (expTxn.size() == 0) begin
        bad++;
        $display("FAIL txn_unexpected addr=%h we=%b", memIf.mem_addr, memIf.mem_we);
      end else begin
        monTxn = expTxn.pop_front();
        if (memIf.mem_we !== monTxn.we || memIf.mem_addr !== monTxn.addr || memIf.mem_wdata !== monTxn.wdata) begin
          bad++;
          $display("FAIL txn got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                   memIf.mem_we, memIf.mem_addr, memIf.mem_wdata, monTxn.we, monTxn.addr, monTxn.wdata);
        end
      end
    end
    if (ReadValidM === 1'b1) begin
      rvCount++;
      total++;
      if (expRead.size() == 0) begin
        bad++;
        $display("FAIL read_valid_unexpected data=%h", ReadDataM);
      end else begin
        monRead = expRead.pop_front();
        if (ReadDataM !== monRead) begin
          bad++;
          $display("FAIL read_data got=%h want=%h", ReadDataM, monRead);
        end
      end
    end
  end

  function automatic logic [VW-1:0] makeVec(input logic [31:0] base, input logic [31:0] step);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = base + step * i;
    return v;
  endfunction

  // Drives one M-stage op, holds it through the stall, drops it in the DONE cycle.
  task automatic runOp(input logic w, input logic r, input logic [31:0] aBase, input logic [31:0] aStep,
                       input logic [31:0] dBase, input logic [31:0] dStep,
                       output int stalls, output logic rvDone);
    logic [VW-1:0] av;
    logic [VW-1:0] dv;
    av = makeVec(aBase, aStep);
    dv = makeVec(dBase, dStep);
    @(negedge CLK);
    ALUResultM = av;
    WriteDataM = dv;
    MemWriteM  = w;
    MemtoRegM  = r;
    for (int i = 0; i < LANES; i++) expTxn.push_back('{we: w, addr: av[i*DW +: AW], wdata: dv[i*DW +: DW]});
    if (!w && r) expRead.push_back(makeVec(aBase + 32'h9F00, aStep));
    stalls = 0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (!StallM) break;
      stalls++;
      @(negedge CLK);
    end
    rvDone     = ReadValidM;
    MemWriteM  = 1'b0;
    MemtoRegM  = 1'b0;
    ALUResultM = '0;
    WriteDataM = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1; MemWriteM = 1'b0; MemtoRegM = 1'b0; ALUResultM = '0; WriteDataM = '0;
    repeat (2) @(negedge CLK);
    #1;
    total++;
    if ({StallM, ReadValidM, memIf.mem_req, memIf.mem_we} !== 4'b0000 || memIf.mem_addr !== '0 ||
        memIf.mem_wdata !== '0 || ReadDataM !== '0) begin
      bad++;
      $display("FAIL reset_state stall=%b rv=%b req=%b we=%b addr=%h wdata=%h rd_nonzero=%b want all 0",
               StallM, ReadValidM, memIf.mem_req, memIf.mem_we, memIf.mem_addr, memIf.mem_wdata, |ReadDataM);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_load_zero_wait();
    int stalls; logic rvd; int rv0;
    rv0 = rvCount;
    runOp(1'b0, 1'b1, 32'h100, 32'd1, 32'h55, 32'd1, stalls, rvd);
    total++; if (stalls !== 17) begin bad++; $display("FAIL load_stall got=%0d want=17", stalls); end
    total++; if (rvd !== 1'b1) begin bad++; $display("FAIL load_rv_at_done got=%b want=1", rvd); end
    repeat (2) @(negedge CLK);
    #1;
    total++; if (ReadDataM !== makeVec(32'hA000, 32'd1)) begin bad++; $display("FAIL load_data got=%h want=%h", ReadDataM, makeVec(32'hA000, 32'd1)); end
    total++; if (rvCount - rv0 !== 1) begin bad++; $display("FAIL load_rv_count got=%0d want=1", rvCount - rv0); end
    total++; if (expTxn.size() != 0 || expRead.size() != 0) begin bad++; $display("FAIL load_queues got=%0d/%0d want=0/0", expTxn.size(), expRead.size()); end
  endtask

  task automatic test_store();
    int stalls; logic rvd; int rv0;
    rv0 = rvCount;
    runOp(1'b1, 1'b0, 32'h200, 32'd4, 32'd0, 32'd3, stalls, rvd);
    total++; if (stalls !== 17) begin bad++; $display("FAIL store_stall got=%0d want=17", stalls); end
    total++; if (rvd !== 1'b0) begin bad++; $display("FAIL store_rv_at_done got=%b want=0", rvd); end
    repeat (2) @(negedge CLK);
    #1;
    total++; if (rvCount - rv0 !== 0) begin bad++; $display("FAIL store_rv_count got=%0d want=0", rvCount - rv0); end
    total++; if (ReadDataM !== makeVec(32'hA000, 32'd1)) begin bad++; $display("FAIL store_keeps_rd got=%h want=%h", ReadDataM, makeVec(32'hA000, 32'd1)); end
    total++; if (expTxn.size() != 0) begin bad++; $display("FAIL store_queue got=%0d want=0", expTxn.size()); end
  endtask

  task automatic test_wait_state();
    int stalls; logic rvd;
    waitAddr = 32'h305;
    waitNeed = 2;
    runOp(1'b0, 1'b1, 32'h300, 32'd1, 32'h0, 32'd0, stalls, rvd);
    total++; if (stalls !== 19) begin bad++; $display("FAIL wait_stall got=%0d want=19", stalls); end
    total++; if (rvd !== 1'b1) begin bad++; $display("FAIL wait_rv_at_done got=%b want=1", rvd); end
    repeat (2) @(negedge CLK);
    #1;
    total++; if (ReadDataM[5*DW +: DW] !== 32'hA205) begin bad++; $display("FAIL wait_lane5 got=%h want=%h", ReadDataM[5*DW +: DW], 32'hA205); end
    waitAddr = '1;
    waitNeed = 0;
  endtask

  task automatic test_both_and_spurious();
    int stalls; logic rvd; int rv0;
    logic [VW-1:0] rdKeep;
    rv0 = rvCount;
    rdKeep = makeVec(32'hA200, 32'd1);
    runOp(1'b1, 1'b1, 32'h500, 32'd1, 32'h77, 32'd1, stalls, rvd);
    total++; if (stalls !== 17) begin bad++; $display("FAIL both_stall got=%0d want=17", stalls); end
    total++; if (rvd !== 1'b0) begin bad++; $display("FAIL both_rv_at_done got=%b want=0", rvd); end
    @(negedge CLK);
    spurAck = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (StallM !== 1'b0 || memIf.mem_req !== 1'b0 || ReadValidM !== 1'b0) begin
        bad++;
        $display("FAIL spurious_ack stall=%b req=%b rv=%b want 0/0/0", StallM, memIf.mem_req, ReadValidM);
      end
      @(negedge CLK);
    end
    spurAck = 1'b0;
    #3;
    total++; if (rvCount - rv0 !== 0) begin bad++; $display("FAIL both_rv_count got=%0d want=0", rvCount - rv0); end
    total++; if (ReadDataM !== rdKeep) begin bad++; $display("FAIL both_keeps_rd got=%h want=%h", ReadDataM, rdKeep); end
    total++; if (expTxn.size() != 0) begin bad++; $display("FAIL both_queue got=%0d want=0", expTxn.size()); end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] av;
    int guard; int rv0; int stalls; logic rvd;
    av = makeVec(32'h400, 32'd1);
    @(negedge CLK);
    ALUResultM = av; WriteDataM = '0; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    for (int i = 0; i < LANES; i++) expTxn.push_back('{we: 1'b0, addr: av[i*DW +: AW], wdata: '0});
    expRead.push_back(makeVec(32'hA300, 32'd1));
    #1;
    guard = 0;
    while (!(memIf.mem_req && memIf.mem_addr == 32'h407) && guard < 100) begin
      @(negedge CLK); #1; guard++;
    end
    total++; if (guard >= 100) begin bad++; $display("FAIL rstmid_reach_lane7 got=timeout want=lane7 request"); end
    RST = 1'b1;
    rv0 = rvCount;
    @(posedge CLK); #1;
    total++;
    if (memIf.mem_req !== 1'b0 || StallM !== 1'b0 || ReadValidM !== 1'b0 || ReadDataM !== '0) begin
      bad++;
      $display("FAIL rstmid_state req=%b stall=%b rv=%b rd_nonzero=%b want 0/0/0/0",
               memIf.mem_req, StallM, ReadValidM, |ReadDataM);
    end
    MemtoRegM = 1'b0; ALUResultM = '0;
    expTxn.delete();
    expRead.delete();
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    #3;
    total++; if (rvCount - rv0 !== 0) begin bad++; $display("FAIL rstmid_no_rv got=%0d want=0", rvCount - rv0); end
    runOp(1'b0, 1'b1, 32'h480, 32'd2, 32'h0, 32'd0, stalls, rvd);
    total++; if (stalls !== 17 || rvd !== 1'b1) begin bad++; $display("FAIL rstmid_reload got stall=%0d rv=%b want 17/1", stalls, rvd); end
    repeat (2) @(negedge CLK);
    #1;
    total++; if (ReadDataM !== makeVec(32'hA380, 32'd2)) begin bad++; $display("FAIL rstmid_reload_data got=%h want=%h", ReadDataM, makeVec(32'hA380, 32'd2)); end
  endtask

  task automatic test_back_to_back();
    int s1; int s2; logic r1; logic r2; int rv0;
    rv0 = rvCount;
    runOp(1'b0, 1'b1, 32'h600, 32'd1, 32'h0, 32'd0, s1, r1);
    runOp(1'b0, 1'b1, 32'h700, 32'd3, 32'h0, 32'd0, s2, r2);
    total++; if (s1 !== 17 || s2 !== 17) begin bad++; $display("FAIL b2b_stall got=%0d/%0d want=17/17", s1, s2); end
    total++; if (r1 !== 1'b1 || r2 !== 1'b1) begin bad++; $display("FAIL b2b_rv_at_done got=%b/%b want=1/1", r1, r2); end
    repeat (3) @(negedge CLK);
    #1;
    total++; if (rvCount - rv0 !== 2) begin bad++; $display("FAIL b2b_rv_count got=%0d want=2", rvCount - rv0); end
    total++; if (ReadDataM !== makeVec(32'hA600, 32'd3)) begin bad++; $display("FAIL b2b_data got=%h want=%h", ReadDataM, makeVec(32'hA600, 32'd3)); end
    total++; if (expTxn.size() != 0 || expRead.size() != 0) begin bad++; $display("FAIL b2b_queues got=%0d/%0d want=0/0", expTxn.size(), expRead.size()); end
  endtask

  initial begin
    test_reset();
    test_load_zero_wait();
    test_store();
    test_wait_state();
    test_both_and_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
